// File: rtl/mem_port_arbiter_pkg.sv
//------------------------------------------------------------------------------
// mem_port_arbiter_pkg : shared types for the unified memory port arbiter
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mem_port_arbiter_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_e;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_wait_state_counter.sv
//------------------------------------------------------------------------------
// wait_state_counter : loadable down counter with zero flag, stops at zero
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module wait_state_counter
    import mem_port_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             dec_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
//------------------------------------------------------------------------------
// mem_port_arbiter : fetch/data arbiter for a single-ported unified memory
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int DATA_W          = 24,
    parameter int WAIT_STATES     = 2,
    parameter int MAX_DATA_STREAK = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetchReq,
    input  logic [DATA_W-1:0] fetchAddr,
    input  logic              fetchAbort,
    output logic              fetchReady,
    output logic [DATA_W-1:0] fetchData,
    input  logic              dataReq,
    input  logic              dataWe,
    input  logic [DATA_W-1:0] dataAddr,
    input  logic [DATA_W-1:0] dataWdata,
    output logic              dataReady,
    output logic [DATA_W-1:0] dataRdata,
    output logic              memEn,
    output logic              memWe,
    output logic [DATA_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWdata,
    input  logic [DATA_W-1:0] memRdata,
    output logic              busy
);

    localparam logic [CNT_W-1:0] WAIT_LD    = CNT_W'(WAIT_STATES);
    localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(MAX_DATA_STREAK);

    state_e            state_q,  state_d;
    owner_e            owner_q,  owner_d;
    logic [DATA_W-1:0] addr_q,   addr_d;
    logic [DATA_W-1:0] wdata_q,  wdata_d;
    logic [DATA_W-1:0] rd_q,     rd_d;
    logic [DATA_W-1:0] fdata_q,  fdata_d;
    logic [DATA_W-1:0] drdata_q, drdata_d;
    logic              we_q,     we_d;
    logic              abort_q,  abort_d;
    logic [CNT_W-1:0]  streak_q, streak_d;
    logic              cnt_load;
    logic              cnt_dec;
    logic              cnt_zero;
    logic              fetch_ok;
    logic              data_ok;
    logic              load_ok;

    wait_state_counter u_wait_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (cnt_load),
        .dec_i      (cnt_dec),
        .load_val_i (WAIT_LD),
        .zero_o     (cnt_zero)
    );

    // An abort arriving in the DONE cycle itself must still kill the pulse.
    assign fetch_ok = (state_q == ST_DONE) && (owner_q == OWN_FETCH) && !abort_q && !fetchAbort;
    assign data_ok  = (state_q == ST_DONE) && (owner_q == OWN_DATA);
    assign load_ok  = data_ok && !we_q;

    assign fetchReady = fetch_ok;
    assign dataReady  = data_ok;
    assign fetchData  = fetch_ok ? rd_q : fdata_q;
    assign dataRdata  = load_ok  ? rd_q : drdata_q;
    assign memEn      = (state_q == ST_BUSY);
    assign memWe      = memEn && we_q;
    assign memAddr    = addr_q;
    assign memWdata   = wdata_q;
    assign busy       = (state_q != ST_IDLE);

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        abort_d  = abort_q;
        streak_d = streak_q;
        rd_d     = rd_q;
        fdata_d  = fdata_q;
        drdata_d = drdata_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (dataReq && ((streak_q < STREAK_MAX) || !fetchReq)) begin
                    state_d  = ST_BUSY;
                    owner_d  = OWN_DATA;
                    addr_d   = dataAddr;
                    wdata_d  = dataWdata;
                    we_d     = dataWe;
                    abort_d  = 1'b0;
                    cnt_load = 1'b1;
                    // fetchReq here implies streak_q < STREAK_MAX, so this saturates.
                    streak_d = fetchReq ? (streak_q + 1'b1) : '0;
                end else if (fetchReq && !fetchAbort) begin
                    state_d  = ST_BUSY;
                    owner_d  = OWN_FETCH;
                    addr_d   = fetchAddr;
                    we_d     = 1'b0;
                    abort_d  = 1'b0;
                    cnt_load = 1'b1;
                    streak_d = '0;
                end
            end
            ST_BUSY: begin
                if ((owner_q == OWN_FETCH) && fetchAbort) begin
                    abort_d = 1'b1;
                end
                if (cnt_zero) begin
                    rd_d    = memRdata;
                    state_d = ST_DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_DONE: begin
                if (fetch_ok) begin
                    fdata_d = rd_q;
                end
                if (load_ok) begin
                    drdata_d = rd_q;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            owner_q  <= OWN_FETCH;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            abort_q  <= 1'b0;
            streak_q <= '0;
            rd_q     <= '0;
            fdata_q  <= '0;
            drdata_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            abort_q  <= abort_d;
            streak_q <= streak_d;
            rd_q     <= rd_d;
            fdata_q  <= fdata_d;
            drdata_q <= drdata_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
//------------------------------------------------------------------------------
// tb_mem_port_arbiter : directed self-checking bench, WAIT_STATES=2 and =0 units
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        a_fetchReq, a_fetchAbort, a_fetchReady, a_dataReq, a_dataWe, a_dataReady;
    logic        a_memEn, a_memWe, a_busy;
    logic [23:0] a_fetchAddr, a_fetchData, a_dataAddr, a_dataWdata, a_dataRdata;
    logic [23:0] a_memAddr, a_memWdata, a_memRdata;

    logic        b_fetchReq, b_fetchAbort, b_fetchReady, b_dataReq, b_dataWe, b_dataReady;
    logic        b_memEn, b_memWe, b_busy;
    logic [23:0] b_fetchAddr, b_fetchData, b_dataAddr, b_dataWdata, b_dataRdata;
    logic [23:0] b_memAddr, b_memWdata, b_memRdata;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(.DATA_W(24), .WAIT_STATES(2), .MAX_DATA_STREAK(3)) u_dut_w2 (
        .clk(clk), .reset(reset),
        .fetchReq(a_fetchReq), .fetchAddr(a_fetchAddr), .fetchAbort(a_fetchAbort),
        .fetchReady(a_fetchReady), .fetchData(a_fetchData),
        .dataReq(a_dataReq), .dataWe(a_dataWe), .dataAddr(a_dataAddr), .dataWdata(a_dataWdata),
        .dataReady(a_dataReady), .dataRdata(a_dataRdata),
        .memEn(a_memEn), .memWe(a_memWe), .memAddr(a_memAddr), .memWdata(a_memWdata),
        .memRdata(a_memRdata), .busy(a_busy)
    );

    mem_port_arbiter #(.DATA_W(24), .WAIT_STATES(0), .MAX_DATA_STREAK(3)) u_dut_w0 (
        .clk(clk), .reset(reset),
        .fetchReq(b_fetchReq), .fetchAddr(b_fetchAddr), .fetchAbort(b_fetchAbort),
        .fetchReady(b_fetchReady), .fetchData(b_fetchData),
        .dataReq(b_dataReq), .dataWe(b_dataWe), .dataAddr(b_dataAddr), .dataWdata(b_dataWdata),
        .dataReady(b_dataReady), .dataRdata(b_dataRdata),
        .memEn(b_memEn), .memWe(b_memWe), .memAddr(b_memAddr), .memWdata(b_memWdata),
        .memRdata(b_memRdata), .busy(b_busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        a_fetchReq = 0; a_fetchAbort = 0; a_dataReq = 0; a_dataWe = 0;
        a_fetchAddr = '0; a_dataAddr = '0; a_dataWdata = '0; a_memRdata = '0;
        b_fetchReq = 0; b_fetchAbort = 0; b_dataReq = 0; b_dataWe = 0;
        b_fetchAddr = '0; b_dataAddr = '0; b_dataWdata = '0; b_memRdata = '0;
        tick; tick;
        total++;
        if ({a_fetchReady, a_dataReady, a_memEn, a_memWe, a_busy} !== 5'b0) begin
            bad++; $display("FAIL reset_ctrl_a: got %b want 00000", {a_fetchReady, a_dataReady, a_memEn, a_memWe, a_busy});
        end
        total++;
        if ({a_fetchData, a_dataRdata, a_memAddr, a_memWdata} !== 96'h0) begin
            bad++; $display("FAIL reset_data_a: got %h want 0", {a_fetchData, a_dataRdata, a_memAddr, a_memWdata});
        end
        total++;
        if ({b_fetchReady, b_dataReady, b_memEn, b_memWe, b_busy} !== 5'b0) begin
            bad++; $display("FAIL reset_ctrl_b: got %b want 00000", {b_fetchReady, b_dataReady, b_memEn, b_memWe, b_busy});
        end
        reset = 1'b0;
        tick;
    endtask

    task automatic test_load;
        a_dataReq = 1; a_dataWe = 0; a_dataAddr = 24'h000010; a_memRdata = 24'hABCDEF;
        for (int c = 1; c <= 4; c++) begin
            tick;
            total++;
            if (a_memEn !== (c <= 3)) begin
                bad++; $display("FAIL load_memEn c%0d: got %b want %b", c, a_memEn, (c <= 3));
            end
            total++;
            if (a_dataReady !== (c == 4) || a_fetchReady !== 1'b0) begin
                bad++; $display("FAIL load_ready c%0d: got d%b f%b want d%b f0", c, a_dataReady, a_fetchReady, (c == 4));
            end
            if (c <= 3) begin
                total++;
                if (a_memAddr !== 24'h000010 || a_memWe !== 1'b0) begin
                    bad++; $display("FAIL load_addr c%0d: got %h we%b want 000010 we0", c, a_memAddr, a_memWe);
                end
            end
        end
        total++;
        if (a_dataRdata !== 24'hABCDEF) begin
            bad++; $display("FAIL load_rdata: got %h want abcdef", a_dataRdata);
        end
        a_dataReq = 0;
        tick;
        total++;
        if (a_dataReady !== 1'b0 || a_busy !== 1'b0 || a_dataRdata !== 24'hABCDEF) begin
            bad++; $display("FAIL load_after: got rdy%b busy%b rd%h want 0 0 abcdef", a_dataReady, a_busy, a_dataRdata);
        end
    endtask

    task automatic test_store;
        a_dataReq = 1; a_dataWe = 1; a_dataAddr = 24'h000020; a_dataWdata = 24'h123456; a_memRdata = 24'h555555;
        for (int c = 1; c <= 4; c++) begin
            tick;
            if (c <= 3) begin
                total++;
                if (a_memEn !== 1'b1 || a_memWe !== 1'b1 || a_memAddr !== 24'h000020 || a_memWdata !== 24'h123456) begin
                    bad++; $display("FAIL store_mem c%0d: got en%b we%b %h %h want 1 1 000020 123456",
                                    c, a_memEn, a_memWe, a_memAddr, a_memWdata);
                end
            end
            total++;
            if (a_dataReady !== (c == 4)) begin
                bad++; $display("FAIL store_ready c%0d: got %b want %b", c, a_dataReady, (c == 4));
            end
        end
        total++;
        if (a_memWe !== 1'b0 || a_dataRdata !== 24'hABCDEF) begin
            bad++; $display("FAIL store_done: got we%b rd%h want we0 abcdef", a_memWe, a_dataRdata);
        end
        a_dataReq = 0; a_dataWe = 0;
        tick;
    endtask

    task automatic test_streak;
        logic [4:0] own_data;
        own_data = 5'b10111;  // bit k = 1 when access k goes to data: D D D F D
        a_fetchReq = 1; a_fetchAddr = 24'h000100;
        a_dataReq  = 1; a_dataWe = 0; a_dataAddr = 24'h000030;
        for (int k = 0; k < 5; k++) begin
            a_memRdata = 24'h110000 + 24'(k);
            tick;
            total++;
            if (a_memAddr !== (own_data[k] ? 24'h000030 : 24'h000100) || a_busy !== 1'b1) begin
                bad++; $display("FAIL streak_grant k%0d: got %h busy%b want %h", k, a_memAddr, a_busy,
                                (own_data[k] ? 24'h000030 : 24'h000100));
            end
            tick; tick; tick;
            total++;
            if (a_dataReady !== own_data[k] || a_fetchReady !== !own_data[k]) begin
                bad++; $display("FAIL streak_ready k%0d: got d%b f%b want d%b", k, a_dataReady, a_fetchReady, own_data[k]);
            end
            if (k == 4) begin
                a_fetchReq = 0; a_dataReq = 0;
            end
            tick;
        end
        total++;
        if (a_fetchData !== 24'h110003 || a_dataRdata !== 24'h110004 || a_busy !== 1'b0) begin
            bad++; $display("FAIL streak_data: got f%h d%h busy%b want 110003 110004 0", a_fetchData, a_dataRdata, a_busy);
        end
    endtask

    task automatic test_abort;
        a_fetchReq = 1; a_fetchAbort = 1; a_fetchAddr = 24'h000200; a_memRdata = 24'h777777;
        tick;
        total++;
        if (a_busy !== 1'b0) begin
            bad++; $display("FAIL abort_idle_block: got busy %b want 0", a_busy);
        end
        a_fetchAbort = 0;
        tick;
        total++;
        if (a_busy !== 1'b1 || a_memAddr !== 24'h000200) begin
            bad++; $display("FAIL abort_grant: got busy%b %h want 1 000200", a_busy, a_memAddr);
        end
        a_fetchAbort = 1;
        tick;
        a_fetchAbort = 0; a_fetchReq = 0;
        tick;
        total++;
        if (a_memEn !== 1'b1) begin
            bad++; $display("FAIL abort_completes: got memEn %b want 1", a_memEn);
        end
        tick;
        total++;
        if (a_fetchReady !== 1'b0 || a_busy !== 1'b1 || a_fetchData !== 24'h110003) begin
            bad++; $display("FAIL abort_suppress: got rdy%b busy%b %h want 0 1 110003", a_fetchReady, a_busy, a_fetchData);
        end
        tick;
        a_fetchReq = 1; a_fetchAddr = 24'h000300; a_memRdata = 24'h888888;
        for (int c = 1; c <= 4; c++) begin
            tick;
            total++;
            if (a_fetchReady !== (c == 4)) begin
                bad++; $display("FAIL abort_refetch c%0d: got %b want %b", c, a_fetchReady, (c == 4));
            end
        end
        total++;
        if (a_fetchData !== 24'h888888) begin
            bad++; $display("FAIL abort_refetch_data: got %h want 888888", a_fetchData);
        end
        a_fetchReq = 0;
        tick;
    endtask

    task automatic test_reset_mid;
        a_dataReq = 1; a_dataWe = 1; a_dataAddr = 24'h000040; a_dataWdata = 24'h999999;
        tick;
        total++;
        if (a_memWe !== 1'b1) begin
            bad++; $display("FAIL rstmid_pre: got memWe %b want 1", a_memWe);
        end
        tick;
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (a_memEn !== 1'b0 || a_memWe !== 1'b0 || a_busy !== 1'b0 || a_memAddr !== 24'h0 || a_dataRdata !== 24'h0) begin
            bad++; $display("FAIL rstmid_async: got en%b we%b busy%b %h %h want 0 0 0 0 0",
                            a_memEn, a_memWe, a_busy, a_memAddr, a_dataRdata);
        end
        a_dataReq = 0; a_dataWe = 0;
        for (int c = 0; c < 2; c++) begin
            tick;
            total++;
            if (a_dataReady !== 1'b0 || a_busy !== 1'b0) begin
                bad++; $display("FAIL rstmid_hold c%0d: got rdy%b busy%b want 0 0", c, a_dataReady, a_busy);
            end
        end
        reset = 1'b0;
        a_dataReq = 1; a_dataAddr = 24'h000050; a_memRdata = 24'h424242;
        for (int c = 1; c <= 4; c++) begin
            tick;
            total++;
            if (a_dataReady !== (c == 4) || a_memEn !== (c <= 3)) begin
                bad++; $display("FAIL rstmid_fresh c%0d: got rdy%b en%b want %b %b", c, a_dataReady, a_memEn, (c == 4), (c <= 3));
            end
        end
        total++;
        if (a_dataRdata !== 24'h424242) begin
            bad++; $display("FAIL rstmid_data: got %h want 424242", a_dataRdata);
        end
        a_dataReq = 0;
        tick;
    endtask

    task automatic test_back_to_back;
        logic [23:0] addr;
        logic [23:0] rdata;
        addr = 24'h000400; rdata = 24'h500000;
        b_fetchReq = 1; b_fetchAddr = addr; b_memRdata = rdata;
        for (int i = 0; i < 9; i++) begin
            tick;
            total++;
            if (b_memEn !== (i % 3 == 0) || b_fetchReady !== (i % 3 == 1)) begin
                bad++; $display("FAIL b2b_cadence i%0d: got en%b rdy%b want %b %b", i, b_memEn, b_fetchReady,
                                (i % 3 == 0), (i % 3 == 1));
            end
            if (i % 3 == 0) begin
                total++;
                if (b_memAddr !== addr) begin
                    bad++; $display("FAIL b2b_addr i%0d: got %h want %h", i, b_memAddr, addr);
                end
            end
            if (i % 3 == 1) begin
                total++;
                if (b_fetchData !== rdata) begin
                    bad++; $display("FAIL b2b_data i%0d: got %h want %h", i, b_fetchData, rdata);
                end
                if (i == 7) begin
                    b_fetchReq = 0;
                end else begin
                    addr = addr + 24'd4; rdata = rdata + 24'd1;
                    b_fetchAddr = addr; b_memRdata = rdata;
                end
            end
        end
        tick;
        total++;
        if (b_busy !== 1'b0 || b_memEn !== 1'b0) begin
            bad++; $display("FAIL b2b_end: got busy%b en%b want 0 0", b_busy, b_memEn);
        end
    endtask

    initial begin
        test_reset;
        test_load;
        test_store;
        test_streak;
        test_abort;
        test_reset_mid;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates the single-ported 24-bit unified memory between the fetch stage (instruction reads) and the execution/memory stage (data loads/stores driven by memWe and the ALU result address).
- Sequences each access through a fixed number of memory wait states.
- Returns the read data with a one-cycle ready pulse.
- Supports branch-induced fetch abort, so a redirected pc never consumes a stale instruction.

Parameters:
- DATA_W, 24, data and address width.
- WAIT_STATES, 2, extra memory cycles per access (0..15).
- MAX_DATA_STREAK, 3, consecutive data grants allowed while fetch is waiting before fetch is forced (1..15).

Ports:
- clk  input  1  clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- fetchReq  input  1  fetch request; held until fetchReady or abort.
- fetchAddr  input  DATA_W  instruction address.
- fetchAbort  input  1  branch taken (pcWe): drop the in-flight or pending fetch.
- fetchReady  output  1  one-cycle pulse; fetchData valid.
- fetchData  output  DATA_W  instruction word.
- dataReq  input  1  data access request; held until dataReady.
- dataWe  input  1  1 = store, 0 = load.
- dataAddr  input  DATA_W  data address.
- dataWdata  input  DATA_W  store data.
- dataReady  output  1  one-cycle pulse; access done, dataRdata valid for loads.
- dataRdata  output  DATA_W  load data.
- memEn  output  1  memory enable.
- memWe  output  1  memory write enable.
- memAddr  output  DATA_W  memory address.
- memWdata  output  DATA_W  memory write data.
- memRdata  input  DATA_W  memory read data, valid on last busy cycle.
- busy  output  1  arbiter not in IDLE.

Behaviour:
- Reset (asynchronous, any time, including mid-access):
  - state = IDLE; all outputs 0; streak counter 0; latched owner/addr/wdata/we cleared.
  - An in-progress store may or may not have reached memory; no ready pulse is ever issued for it.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If dataReq and (streak < MAX_DATA_STREAK or !fetchReq), grant data.
  - Else if fetchReq and !fetchAbort, grant fetch.
  - On grant: latch owner, addr, wdata, we; load waitCnt = WAIT_STATES; go to BUSY. Otherwise stay.
- BUSY:
  - memEn = 1; memAddr/memWdata come from latched values; memWe = latched we (held every busy cycle; idempotent).
  - waitCnt decrements each cycle; at waitCnt == 0, capture memRdata into the owner's data register and go to DONE.
  - Occupancy is WAIT_STATES+1 cycles.
- DONE:
  - Pulse the owner's ready for exactly one cycle, then return to IDLE.
  - No new grant is issued in DONE, giving one bubble per access.
- Latency: a request sampled in IDLE at edge t gives ready high during cycle t+WAIT_STATES+2. Throughput is one access per WAIT_STATES+3 cycles.
- Requester rule: drop req (or present the next request) in the cycle ready is high. The arbiter does not sample req outside IDLE.
- Streak counter:
  - Increments on each data grant made while fetchReq = 1; saturates at MAX_DATA_STREAK.
  - Clears on any fetch grant, or on a data grant made while fetchReq = 0.
  - At saturation, a pending fetch wins over data.
- fetchAbort:
  - Asserted in IDLE, it blocks the fetch grant that cycle.
  - Asserted while the fetch owns BUSY or DONE, the memory access completes but fetchReady is suppressed; fetchData is not updated.
  - It has no effect on data transactions.
- Outputs not owned hold their last value; readies are 0 except in DONE.
- dataRdata is updated only on loads.
- Address and data are passed through unmodified; no alignment or width conversion.

Decomposition:
- Shared package: state enum (IDLE, BUSY, DONE) and an owner enum (OWN_FETCH, OWN_DATA).
- One natural sub-module: wait_state_counter (loadable 4-bit down counter with zero flag), reusable for other multi-cycle units.

Test Plan:
1. WAIT_STATES=2, single load: dataReq=1, dataWe=0, dataAddr=0x000010, memRdata=0xABCDEF on last busy cycle -> memEn high 3 cycles, dataReady pulses at t+4, dataRdata=0xABCDEF, fetchReady stays 0.
2. Store: dataWe=1, dataAddr=0x000020, dataWdata=0x123456 -> memWe=1 with memAddr=0x000020 and memWdata=0x123456 for 3 cycles, dataReady at t+4.
3. Simultaneous fetchReq and dataReq held continuously, MAX_DATA_STREAK=3 -> grant order data, data, data, fetch, data... and the fetch grant clears the streak.
4. Fetch in BUSY, fetchAbort pulsed for 1 cycle -> memory access completes, no fetchReady, fetchData unchanged; a new fetchReq afterwards is granted normally.
5. Reset asserted mid-BUSY (asynchronously, between edges) -> memEn/memWe/busy drop immediately, no ready pulse; after release a fresh request gets full latency.
6. WAIT_STATES=0 back-to-back fetches -> fetchReady every 3 cycles, memEn high exactly 1 cycle per access.
